// File: rtl/cdc_src_stim.sv
// Source-side four-phase req/ack stimulus generator for CDC handshake benches.
// Issues NUM_XFERS incrementing data words and flags stalled handshakes.
module cdc_src_stim #(
    parameter int unsigned          DATA_W     = 32,
    parameter int unsigned          NUM_XFERS  = 16,
    parameter int unsigned          GAP_CYCLES = 4,
    parameter int unsigned          TIMEOUT    = 1024,
    parameter logic [DATA_W-1:0]    SEED       = '0
) (
    input  logic              src_clk,
    input  logic              src_reset,
    input  logic              start,
    output logic              src_req,
    output logic [DATA_W-1:0] src_data,
    input  logic              src_ack,
    output logic              busy,
    output logic              done,
    output logic [31:0]       sent_count,
    output logic              timeout_err
);

    localparam logic [31:0] NUM_L    = 32'(NUM_XFERS);
    localparam logic [31:0] GAP_LD   = 32'(GAP_CYCLES) - 32'd1;
    localparam logic [31:0] WAIT_MAX = 32'(TIMEOUT) - 32'd1;
    localparam bit          NO_GAP   = (GAP_CYCLES == 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_REL,
        S_GAP,
        S_DONE
    } state_t;

    state_t              state_q;
    logic                req_q;
    logic [DATA_W-1:0]   data_q;
    logic [31:0]         sent_q;
    logic [31:0]         wait_q;
    logic [31:0]         gap_q;
    logic                done_q;
    logic                terr_q;

    logic                launch_d;
    logic                wait_hit_d;
    logic [DATA_W-1:0]   data_inc_d;

    assign launch_d   = start && !src_ack;
    assign wait_hit_d = (wait_q == WAIT_MAX);
    assign data_inc_d = data_q + DATA_W'(1);

    always_ff @(posedge src_clk) begin
        if (src_reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            data_q  <= '0;
            sent_q  <= '0;
            wait_q  <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
            terr_q  <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE, S_DONE: begin
                    if (launch_d) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                        data_q  <= SEED;
                        sent_q  <= '0;
                        wait_q  <= '0;
                        done_q  <= 1'b0;
                        terr_q  <= 1'b0;
                    end
                end
                S_REQ: begin
                    if (src_ack) begin
                        state_q <= S_REL;
                        req_q   <= 1'b0;
                        sent_q  <= sent_q + 32'd1;
                        wait_q  <= '0;
                    end else if (wait_hit_d) begin
                        state_q <= S_DONE;
                        req_q   <= 1'b0;
                        done_q  <= 1'b1;
                        terr_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_REL: begin
                    if (!src_ack) begin
                        wait_q <= '0;
                        if (sent_q == NUM_L) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else if (NO_GAP) begin
                            state_q <= S_REQ;
                            req_q   <= 1'b1;
                            data_q  <= data_inc_d;
                        end else begin
                            state_q <= S_GAP;
                            data_q  <= data_inc_d;
                            gap_q   <= GAP_LD;
                        end
                    end else if (wait_hit_d) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        terr_q  <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 32'd1;
                    end
                end
                S_GAP: begin
                    if (gap_q == 32'd0) begin
                        state_q <= S_REQ;
                        req_q   <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 32'd1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign src_req     = req_q;
    assign src_data    = data_q;
    assign sent_count  = sent_q;
    assign done        = done_q;
    assign timeout_err = terr_q;
    assign busy        = (state_q == S_REQ) || (state_q == S_REL) ||
                         (state_q == S_GAP);

endmodule
